// File: rtl/tick_timer.sv
// Prescaled 32-bit timer with compare match, one-shot/periodic mode and a
// level interrupt, accessed through a simple request/response register port.
module tick_timer #(
    parameter int unsigned AW = 5,
    parameter int unsigned PW = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          reg_req_i,
    input  logic          reg_we_i,
    input  logic [AW-1:0] reg_addr_i,
    input  logic [31:0]   reg_wdata_i,
    input  logic [3:0]    reg_be_i,
    output logic [31:0]   reg_rdata_o,
    output logic          reg_rvalid_o,
    output logic          reg_error_o,
    output logic          intr_o
);

    localparam int unsigned IW = AW - 2;
    localparam logic [IW-1:0] A_CTRL     = IW'(0);
    localparam logic [IW-1:0] A_PRESCALE = IW'(1);
    localparam logic [IW-1:0] A_COUNT    = IW'(2);
    localparam logic [IW-1:0] A_COMPARE  = IW'(3);
    localparam logic [IW-1:0] A_ISTATE   = IW'(4);
    localparam logic [IW-1:0] A_IENABLE  = IW'(5);

    logic          en_q, en_d;
    logic          periodic_q, periodic_d;
    logic [PW-1:0] prescale_q, prescale_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          intr_state_q, intr_state_d;
    logic          intr_enable_q, intr_enable_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          error_q, error_d;
    logic          intr_q, intr_d;

    logic [IW-1:0] idx_c;
    logic          mapped_c;
    logic          wr_c;
    logic          tick_c;
    logic          hit_c;
    logic [31:0]   rdata_c;
    logic          unused_addr;

    assign idx_c       = reg_addr_i[AW-1:2];
    assign unused_addr = ^reg_addr_i[1:0];
    assign mapped_c    = (idx_c <= A_IENABLE);
    assign wr_c        = reg_req_i & reg_we_i & mapped_c;
    assign tick_c      = en_q & (pcnt_q == prescale_q);
    assign hit_c       = tick_c & (count_q == compare_q);

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return r;
    endfunction

    // Read mux: values are those held before any same-cycle write lands.
    always_comb begin
        rdata_c = '0;
        case (idx_c)
            A_CTRL:     rdata_c = {30'd0, periodic_q, en_q};
            A_PRESCALE: rdata_c = 32'(prescale_q);
            A_COUNT:    rdata_c = count_q;
            A_COMPARE:  rdata_c = compare_q;
            A_ISTATE:   rdata_c = {31'd0, intr_state_q};
            A_IENABLE:  rdata_c = {31'd0, intr_enable_q};
            default:    rdata_c = '0;
        endcase
    end

    // Next state: timer advance first, then software writes override it.
    always_comb begin
        en_d          = en_q;
        periodic_d    = periodic_q;
        prescale_d    = prescale_q;
        compare_d     = compare_q;
        intr_enable_d = intr_enable_q;
        pcnt_d        = (en_q && !tick_c) ? pcnt_q + PW'(1) : '0;
        count_d       = count_q;
        intr_state_d  = intr_state_q | hit_c;

        if (tick_c) begin
            count_d = (hit_c && periodic_q) ? '0 : count_q + 32'd1;
        end

        if (wr_c) begin
            case (idx_c)
                A_CTRL: begin
                    en_d       = reg_wdata_i[0];
                    periodic_d = reg_wdata_i[1];
                end
                A_PRESCALE: begin
                    prescale_d = PW'(byte_merge(32'(prescale_q), reg_wdata_i, reg_be_i));
                    pcnt_d     = '0;
                end
                A_COUNT:   count_d   = byte_merge(count_q, reg_wdata_i, reg_be_i);
                A_COMPARE: compare_d = byte_merge(compare_q, reg_wdata_i, reg_be_i);
                A_ISTATE: begin
                    if (reg_wdata_i[0] && !hit_c) intr_state_d = 1'b0;
                end
                A_IENABLE: intr_enable_d = reg_wdata_i[0];
                default: ;
            endcase
        end

        rvalid_d = reg_req_i;
        error_d  = reg_req_i & ~mapped_c;
        rdata_d  = (reg_req_i && !reg_we_i) ? rdata_c : '0;
        intr_d   = intr_state_q & intr_enable_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            en_q          <= 1'b0;
            periodic_q    <= 1'b0;
            prescale_q    <= '0;
            pcnt_q        <= '0;
            count_q       <= '0;
            compare_q     <= '0;
            intr_state_q  <= 1'b0;
            intr_enable_q <= 1'b0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            error_q       <= 1'b0;
            intr_q        <= 1'b0;
        end else begin
            en_q          <= en_d;
            periodic_q    <= periodic_d;
            prescale_q    <= prescale_d;
            pcnt_q        <= pcnt_d;
            count_q       <= count_d;
            compare_q     <= compare_d;
            intr_state_q  <= intr_state_d;
            intr_enable_q <= intr_enable_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
            error_q       <= error_d;
            intr_q        <= intr_d;
        end
    end

    assign reg_rdata_o  = rdata_q;
    assign reg_rvalid_o = rvalid_q;
    assign reg_error_o  = error_q;
    assign intr_o       = intr_q;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: reset table, directed corner sequences
// and randomized register traffic against a behavioural timer model.
module tb_tick_timer;

    logic        clock;
    logic        reset;
    logic        reg_req_i;
    logic        reg_we_i;
    logic [4:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [3:0]  reg_be_i;
    logic [31:0] reg_rdata_o;
    logic        reg_rvalid_o;
    logic        reg_error_o;
    logic        intr_o;

    tick_timer #(.AW(5), .PW(12)) dut (
        .clock        (clock),
        .reset        (reset),
        .reg_req_i    (reg_req_i),
        .reg_we_i     (reg_we_i),
        .reg_addr_i   (reg_addr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_be_i     (reg_be_i),
        .reg_rdata_o  (reg_rdata_o),
        .reg_rvalid_o (reg_rvalid_o),
        .reg_error_o  (reg_error_o),
        .intr_o       (intr_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_rdata;

    // Behavioural model: register file plus "cycles elapsed in this tick period".
    logic        m_en, m_per, m_ist, m_ien;
    logic [11:0] m_pre;
    logic [31:0] m_cnt, m_cmp;
    int unsigned m_phase;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        case (idx)
            0: return {30'd0, m_per, m_en};
            1: return {20'd0, m_pre};
            2: return m_cnt;
            3: return m_cmp;
            4: return {31'd0, m_ist};
            5: return {31'd0, m_ien};
            default: return 32'd0;
        endcase
    endfunction

    // One clock cycle: drive inputs, predict, clock, then compare.
    task automatic step(input logic rst, input logic req, input logic we, input logic [4:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        int          idx;
        logic        mapped, tick, hit;
        logic        e_rv, e_err, e_intr;
        logic [31:0] e_rd;
        logic        n_en, n_per, n_ist, n_ien;
        logic [11:0] n_pre;
        logic [31:0] n_cnt, n_cmp;
        int unsigned n_phase;

        reset = rst; reg_req_i = req; reg_we_i = we;
        reg_addr_i = addr; reg_wdata_i = wdata; reg_be_i = be;

        idx    = int'(addr[4:2]);
        mapped = (idx <= 5);
        e_rv   = !rst && req;
        e_err  = !rst && req && !mapped;
        e_rd   = (!rst && req && !we && mapped) ? m_read(idx) : 32'd0;
        e_intr = !rst && m_ist && m_ien;

        tick    = m_en && (m_phase == 32'(m_pre));
        hit     = tick && (m_cnt == m_cmp);
        n_cnt   = !tick ? m_cnt : ((hit && m_per) ? 32'd0 : m_cnt + 32'd1);
        n_phase = (m_en && !tick) ? m_phase + 1 : 0;
        n_ist   = m_ist || hit;
        n_en = m_en; n_per = m_per; n_pre = m_pre; n_cmp = m_cmp; n_ien = m_ien;

        if (req && we && mapped) begin
            case (idx)
                0: begin n_en = wdata[0]; n_per = wdata[1]; end
                1: begin n_pre = 12'(bmerge({20'd0, m_pre}, wdata, be)); n_phase = 0; end
                2: n_cnt = bmerge(m_cnt, wdata, be);
                3: n_cmp = bmerge(m_cmp, wdata, be);
                4: if (wdata[0] && !hit) n_ist = 1'b0;
                5: n_ien = wdata[0];
                default: ;
            endcase
        end
        if (rst) begin
            n_en = 0; n_per = 0; n_pre = 0; n_cnt = 0; n_cmp = 0;
            n_ist = 0; n_ien = 0; n_phase = 0;
        end

        @(posedge clock);
        #1;
        m_en = n_en; m_per = n_per; m_pre = n_pre; m_cnt = n_cnt; m_cmp = n_cmp;
        m_ist = n_ist; m_ien = n_ien; m_phase = n_phase;

        check("rvalid", 32'(reg_rvalid_o), 32'(e_rv));
        check("intr_o", 32'(intr_o), 32'(e_intr));
        if (e_rv) check("error", 32'(reg_error_o), 32'(e_err));
        if (e_rv && !we) check("rdata", reg_rdata_o, e_rd);
        last_rdata = reg_rdata_o;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, a, d, 4'hf);
    endtask
    task automatic rd(input logic [4:0] a);
        step(1'b0, 1'b1, 1'b0, a, 32'd0, 4'h0);
    endtask
    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t tbl[11];

    task automatic run_table();
        foreach (tbl[i]) begin
            step(1'b0, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be);
            check("tbl_rvalid", 32'(reg_rvalid_o), 32'd1);
            check("tbl_error", 32'(reg_error_o), 32'(tbl[i].exp_err));
            if (!tbl[i].we) check("tbl_rdata", reg_rdata_o, tbl[i].exp_rd);
        end
    endtask

    initial begin
        reset = 1'b1; reg_req_i = 0; reg_we_i = 0; reg_addr_i = 0; reg_wdata_i = 0; reg_be_i = 0;
        m_en = 0; m_per = 0; m_ist = 0; m_ien = 0; m_pre = 0; m_cnt = 0; m_cmp = 0; m_phase = 0;
        last_rdata = 0;

        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b0, 5'(i * 4), 32'd0, 4'h0, 32'd0, (i >= 6)};
        tbl[8]  = '{1'b1, 5'h18, 32'hFFFF_FFFF, 4'hf, 32'd0, 1'b1};
        tbl[9]  = '{1'b0, 5'h0B, 32'd0, 4'h0, 32'd0, 1'b0};
        tbl[10] = '{1'b0, 5'h18, 32'd0, 4'h0, 32'd0, 1'b1};

        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
        check("reset_rvalid", 32'(reg_rvalid_o), 32'd0);
        check("reset_intr", 32'(intr_o), 32'd0);
        run_table();

        // Prescaled one-shot: tick every 4 cycles, match at COUNT=5.
        wr(5'h04, 3); wr(5'h0C, 5); wr(5'h14, 1); wr(5'h00, 1);
        repeat (24) idle();
        check("pre_intr_low", 32'(intr_o), 32'd0);
        idle();
        check("pre_intr_high", 32'(intr_o), 32'd1);
        rd(5'h08);
        check("pre_count_after", last_rdata, 32'd6);

        // Periodic: COUNT cycles 0,1,2.
        wr(5'h00, 0); wr(5'h10, 1); wr(5'h08, 0); wr(5'h04, 0); wr(5'h0C, 2); wr(5'h00, 3);
        for (int k = 0; k < 6; k++) begin
            rd(5'h08);
            check("per_seq", last_rdata, 32'(k % 3));
        end
        wr(5'h00, 0); wr(5'h10, 1); idle();
        check("per_intr_fall", 32'(intr_o), 32'd0);
        wr(5'h00, 3);
        repeat (4) idle();
        rd(5'h10);
        check("per_reset", last_rdata, 32'd1);

        // Wrap from all-ones with no interrupt, then match at 0x10.
        wr(5'h00, 0); wr(5'h10, 1); wr(5'h08, 32'hFFFF_FFFF); wr(5'h0C, 32'h10);
        wr(5'h04, 0); wr(5'h00, 1);
        rd(5'h08); check("wrap_pre", last_rdata, 32'hFFFF_FFFF);
        rd(5'h08); check("wrap_zero", last_rdata, 32'd0);
        rd(5'h10); check("wrap_noflag", last_rdata, 32'd0);
        repeat (16) idle();
        rd(5'h10); check("wrap_match", last_rdata, 32'd1);

        // COUNT byte write lands on a tick cycle: increment lost.
        wr(5'h00, 0); wr(5'h08, 0); wr(5'h04, 3); wr(5'h0C, 32'hFFFF); wr(5'h00, 1);
        repeat (3) idle();
        step(1'b0, 1'b1, 1'b1, 5'h08, 32'h100, 4'b0010);
        rd(5'h08); check("coll_count", last_rdata, 32'h100);

        // W1C in the match cycle: flag stays set.
        wr(5'h00, 0); wr(5'h08, 0); wr(5'h04, 0); wr(5'h0C, 2); wr(5'h00, 3);
        idle(); idle();
        wr(5'h10, 1);
        rd(5'h10); check("coll_w1c_keep", last_rdata, 32'd1);
        wr(5'h10, 1);
        rd(5'h10); check("coll_w1c_clear", last_rdata, 32'd0);

        // Reset with a read in flight while running.
        wr(5'h00, 1);
        step(1'b1, 1'b1, 1'b0, 5'h08, 32'd0, 4'h0);
        check("rst_rvalid", 32'(reg_rvalid_o), 32'd0);
        check("rst_intr", 32'(intr_o), 32'd0);
        run_table();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            int unsigned r, idx;
            logic [31:0] d;
            r   = $urandom_range(0, 99);
            idx = $urandom_range(0, 7);
            case (idx)
                0:       d = 32'($urandom_range(0, 3));
                1:       d = 32'($urandom_range(0, 3));
                2, 3:    d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 24));
                4:       d = 32'($urandom_range(0, 1));
                default: d = $urandom;
            endcase
            step(r == 0, r < 70, 1'($urandom_range(0, 1)),
                 {3'(idx), 2'($urandom_range(0, 3))}, d, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
